// File: rtl/evt_burst_pkg.sv
// Shared types and default sizing for the event burst generator.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package evt_burst_pkg;

    // Default sizing: a 640-strobe row with up to 15 idle cycles between strobes.
    localparam int MAX_COUNT_DEF = 640;
    localparam int MAX_GAP_DEF   = 15;

    // Width of a burst length (0..MAX_COUNT) and of a gap value (0..MAX_GAP).
    localparam int CW = $clog2(MAX_COUNT_DEF + 1);
    localparam int GW = $clog2(MAX_GAP_DEF + 1);

    // Burst sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EMIT   = 2'd1,
        GAP    = 2'd2,
        FINISH = 2'd3
    } state_e;

endpackage : evt_burst_pkg

// File: rtl/evt_burst_gen_gap_timer.sv
// Loadable down-counter that times the idle gap between two strobes.
// Latency: expire_out is high in the cycle in which the count equals 1.
// Backpressure: none; load_in overrides the countdown in the same cycle.
module gap_timer #(
    parameter int GW = 4
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    input  logic          load_in,
    input  logic [GW-1:0] value_in,
    output logic          expire_out
);

    logic [GW-1:0] cnt_q;
    logic [GW-1:0] cnt_d;

    // Load a fresh gap, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_in) begin
            cnt_d = value_in;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - GW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Count of 1 means the final idle cycle: the next cycle is a strobe.
    assign expire_out = (cnt_q == GW'(1));

endmodule : gap_timer

// File: rtl/evt_burst_gen.sv
// Emits a burst of len single-cycle strobes spaced by gap idle cycles, tagged with index, then done.
// Latency: first strobe one cycle after the start is accepted; done one cycle after the last strobe.
// Backpressure: start_in is only accepted while ready_out=1; starts at other times are dropped.
module evt_burst_gen
    import evt_burst_pkg::*;
#(
    parameter int MAX_COUNT = MAX_COUNT_DEF,
    parameter int MAX_GAP   = MAX_GAP_DEF
) (
    input  logic                           clk_in,
    input  logic                           rst_n_in,
    input  logic                           start_in,
    input  logic [$clog2(MAX_COUNT+1)-1:0] len_in,
    input  logic [$clog2(MAX_GAP+1)-1:0]   gap_in,
    input  logic                           abort_in,
    output logic                           ready_out,
    output logic                           busy_out,
    output logic                           evt_out,
    output logic [$clog2(MAX_COUNT)-1:0]   index_out,
    output logic                           done_out
);

    localparam int LW = $clog2(MAX_COUNT + 1);
    localparam int GL = $clog2(MAX_GAP + 1);
    localparam int IW = $clog2(MAX_COUNT);

    state_e        state_q;
    state_e        state_d;
    logic [IW-1:0] last_q;     // index of the final strobe of the burst
    logic [IW-1:0] last_d;
    logic [GL-1:0] gap_q;      // gap latched at acceptance
    logic [GL-1:0] gap_d;
    logic [IW-1:0] idx_q;      // index of the current or most recent strobe
    logic [IW-1:0] idx_d;

    logic          tmr_load;
    logic          tmr_expire;

    logic [LW-1:0] len_clamped;

    // Requests longer than the counter range are cut to MAX_COUNT strobes.
    always_comb begin
        len_clamped = len_in;
        if (len_in > LW'(MAX_COUNT)) begin
            len_clamped = LW'(MAX_COUNT);
        end
    end

    // Sequencer next state, burst parameter capture and index advance.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        gap_d    = gap_q;
        idx_d    = idx_q;
        tmr_load = 1'b0;

        case (state_q)
            IDLE: begin
                // abort_in has no meaning here, so a simultaneous start simply wins.
                if (start_in) begin
                    last_d = IW'(len_clamped - LW'(1));
                    gap_d  = gap_in;
                    idx_d  = '0;
                    if (len_clamped == '0) begin
                        state_d = FINISH;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end

            EMIT: begin
                // The strobe in this cycle counts as emitted even when aborted.
                if (abort_in || (idx_q == last_q)) begin
                    state_d = FINISH;
                end else if (gap_q == '0) begin
                    idx_d = idx_q + IW'(1);
                end else begin
                    state_d  = GAP;
                    tmr_load = 1'b1;
                end
            end

            GAP: begin
                if (abort_in) begin
                    state_d = FINISH;
                end else if (tmr_expire) begin
                    state_d = EMIT;
                    idx_d   = idx_q + IW'(1);
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst parameters and index registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            last_q  <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
        end
    end

    // Idle-gap timer, loaded on the strobe that precedes each gap.
    gap_timer #(
        .GW (GL)
    ) u_gap_timer (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .load_in    (tmr_load),
        .value_in   (gap_q),
        .expire_out (tmr_expire)
    );

    // Outputs decode straight from registers; no input reaches an output combinationally.
    assign ready_out = (state_q == IDLE);
    assign busy_out  = (state_q == EMIT) || (state_q == GAP);
    assign evt_out   = (state_q == EMIT);
    assign done_out  = (state_q == FINISH);
    assign index_out = idx_q;

endmodule : evt_burst_gen
